iob_axi_mem_responder: RTL and testbench
========================================

# iob_axi_mem_responder

AXI4 burst responder (subordinate) backed by an internal single-port synchronous RAM; it is the target end of the SoC `mem_axi` initiator port. It sits in place of external DDR in simulation and small FPGA builds. It accepts INCR and FIXED bursts on separate read and write channels, one transaction at a time, with fair arbitration between reads and writes.

## Interface
- `AXI_ID_W`, 1: ID width.
- `AXI_LEN_W`, 8: burst length field width.
- `AXI_ADDR_W`, 14: byte-address width. RAM holds 2^(AXI_ADDR_W−log2(AXI_DATA_W/8)) words.
- `AXI_DATA_W`, 32: data width; must be a power of 2, ≥ 8.
- `clk_i` in 1: clock.
- `arst_i` in 1: reset. One clock; reset is asynchronous and active-high.
- `cke_i` in 1: clock enable. Low freezes all state and outputs.
- `axi_awid_i` / `axi_awaddr_i` / `axi_awlen_i` / `axi_awsize_i` / `axi_awburst_i` in ID/ADDR/LEN/3/2: write address.
- `axi_awvalid_i` in 1, `axi_awready_o` out 1: write address handshake.
- `axi_wdata_i` / `axi_wstrb_i` / `axi_wlast_i` in DATA/DATA÷8/1: write data.
- `axi_wvalid_i` in 1, `axi_wready_o` out 1: write data handshake.
- `axi_bid_o` / `axi_bresp_o` out ID/2: write response.
- `axi_bvalid_o` out 1, `axi_bready_i` in 1: write response handshake.
- `axi_arid_i` / `axi_araddr_i` / `axi_arlen_i` / `axi_arsize_i` / `axi_arburst_i` in ID/ADDR/LEN/3/2: read address.
- `axi_arvalid_i` in 1, `axi_arready_o` out 1: read address handshake.
- `axi_rid_o` / `axi_rdata_o` / `axi_rresp_o` / `axi_rlast_o` out ID/DATA/2/1: read data.
- `axi_rvalid_o` out 1, `axi_rready_i` in 1: read data handshake.

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA. Only one transaction is active at a time.
- IDLE arbitration:
  - `awready_o` = awvalid ∧ (¬arvalid ∨ prio=W).
  - `arready_o` = arvalid ∧ (¬awvalid ∨ prio=R).
  - `prio` flips to the other side after each grant. It resets to W.
- On a grant, latch id, word address (byte address ≫ log2(DATA_W/8)), len, and burst. Beat counter = len.
- Error flag is set on grant if:
  - burst ∉ {FIXED=00, INCR=01}, or
  - size ≠ log2(DATA_W/8).
- WDATA:
  - `wready_o` = 1.
  - On each W handshake, write the strobed bytes to RAM, unless the error flag is set (no RAM write).
  - INCR advances the word address by 1. FIXED holds it.
  - At the final counted beat, go to WRESP.
  - A wlast value that disagrees with the beat count (early or missing) sets the error flag. The beat count, not wlast, ends the burst.
- WRESP:
  - `bvalid_o` = 1, `bid_o` = latched id, `bresp_o` = error ? SLVERR (10) : OKAY (00).
  - On bready, go to IDLE.
- RDATA:
  - RAM read is enabled when (¬rvalid ∨ rready) ∧ beats remain to issue.
  - `rvalid_o` rises the cycle after an issue. It holds, with stable data, while rready is low.
  - `rlast_o` is high on the final beat.
  - `rresp_o` = SLVERR with rdata = 0 when the error flag is set.
  - After the last beat handshake, go to IDLE.
- Address arithmetic is modulo RAM depth; upper bits wrap silently. 4 KB boundary crossing is not checked.
- Reset values:
  - All ready/valid outputs 0.
  - rdata, rresp, rlast, rid, bid, bresp all 0.
  - FSM in IDLE, prio = W.
  - RAM contents are undefined.
- Reset asserted mid-burst aborts the transaction. No response is issued for it.

## Timing
- AW/AR accept: same cycle as valid when in IDLE and granted. Ready depends combinationally on valid.
- Write: W accepts start the cycle after the AW handshake, 1 beat/cycle. bvalid asserts 1 cycle after the last W handshake.
- Read: AR handshake in cycle T gives the first rvalid in T+2. Then 1 beat/cycle with rready held high.
- Transaction turnaround:
  - After a B handshake, the next AW/AR can be accepted 1 cycle later.
  - After the last R handshake, the next AW/AR can be accepted 1 cycle later.
- Minimum write transaction: 3 cycles. Minimum read transaction: 3 cycles.

## Test plan
- Single beat: write 0xDEADBEEF at 0x10 with wstrb=F, then read 0x10 → rdata=0xDEADBEEF, rresp=00, rlast=1, bresp=00, rid/bid echo the request ids.
- INCR burst: len=3 at 0x100, data 1..4, then read back → 4 beats 1,2,3,4, rlast only on the 4th, first rvalid at T+2. Randomized rready stalls keep rdata stable while rvalid ∧ ¬rready.
- Partial strobe and FIXED: write 0xFFFFFFFF, then FIXED len=1 with wstrb=0001, data 0x11 then 0x22 → read returns 0xFFFFFF22.
- Arbitration: awvalid and arvalid asserted together from reset → write granted first, then read. Repeat → the grant order alternates.
- Errors:
  - awsize=1 → bresp=10, RAM unchanged.
  - arburst=10 len=1 → 2 beats with rresp=10, rdata=0.
  - wlast early on beat 1 of len=3 → bresp=10.
- Reset mid-read burst after beat 1 → outputs return to reset values asynchronously. The next transaction completes normally.

Source files
------------

// File: rtl/iob_axi_mem_responder.sv
// AXI4 subordinate backed by an internal single-port synchronous RAM.
// Serves one INCR/FIXED burst at a time, alternating priority between reads and writes.
//
// state | meaning
// IDLE  | waiting for AW/AR; arbitrates using prio_q
// WDATA | accepting write beats, one per cycle
// WRESP | presenting the write response on B
// RDATA | issuing RAM reads and presenting beats on R
module iob_axi_mem_responder #(
    parameter int AXI_ID_W   = 1,
    parameter int AXI_LEN_W  = 8,
    parameter int AXI_ADDR_W = 14,
    parameter int AXI_DATA_W = 32
) (
    input  logic                    clk_i,
    input  logic                    arst_i,
    input  logic                    cke_i,
    input  logic [AXI_ID_W-1:0]     axi_awid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_awaddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_awlen_i,
    input  logic [2:0]              axi_awsize_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,
    input  logic [AXI_DATA_W-1:0]   axi_wdata_i,
    input  logic [AXI_DATA_W/8-1:0] axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,
    output logic [AXI_ID_W-1:0]     axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,
    input  logic [AXI_ID_W-1:0]     axi_arid_i,
    input  logic [AXI_ADDR_W-1:0]   axi_araddr_i,
    input  logic [AXI_LEN_W-1:0]    axi_arlen_i,
    input  logic [2:0]              axi_arsize_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,
    output logic [AXI_ID_W-1:0]     axi_rid_o,
    output logic [AXI_DATA_W-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i
);

    localparam int STRB_W   = AXI_DATA_W / 8;
    localparam int SIZE_LOG = $clog2(STRB_W);
    localparam int WORD_AW  = AXI_ADDR_W - SIZE_LOG;
    localparam int DEPTH    = 1 << WORD_AW;

    localparam logic [2:0]           FULL_SIZE = 3'(SIZE_LOG);
    localparam logic [WORD_AW-1:0]   ADDR_ONE  = WORD_AW'(1);
    localparam logic [AXI_LEN_W-1:0] LEN_ONE   = AXI_LEN_W'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WDATA = 2'd1;
    localparam logic [1:0] ST_WRESP = 2'd2;
    localparam logic [1:0] ST_RDATA = 2'd3;

    logic [1:0]            state_q;
    logic                  prio_q;      // 0: write side wins a tie, 1: read side wins
    logic [AXI_ID_W-1:0]   id_q;
    logic [WORD_AW-1:0]    addr_q;
    logic [AXI_LEN_W-1:0]  cnt_q;
    logic                  fixed_q;
    logic                  err_q;
    logic                  rd_more_q;
    logic                  rvalid_q;
    logic                  rlast_q;
    logic [AXI_DATA_W-1:0] ram_q;
    logic [AXI_DATA_W-1:0] mem [DEPTH];

    logic aw_grant, ar_grant, w_hs, r_hs, rd_issue, ram_we, last_beat;
    logic aw_err, ar_err;
    logic unused_addr_bits;

    assign aw_grant  = cke_i && (state_q == ST_IDLE) && axi_awvalid_i && (!axi_arvalid_i || !prio_q);
    assign ar_grant  = cke_i && (state_q == ST_IDLE) && axi_arvalid_i && (!axi_awvalid_i || prio_q);
    assign w_hs      = cke_i && (state_q == ST_WDATA) && axi_wvalid_i;
    assign r_hs      = cke_i && rvalid_q && axi_rready_i;
    assign last_beat = (cnt_q == '0);
    assign rd_issue  = cke_i && (state_q == ST_RDATA) && rd_more_q && (!rvalid_q || axi_rready_i);
    assign ram_we    = w_hs && !err_q;

    assign aw_err = axi_awburst_i[1] || (axi_awsize_i != FULL_SIZE);
    assign ar_err = axi_arburst_i[1] || (axi_arsize_i != FULL_SIZE);

    // Byte offset bits are ignored; the fold keeps every address bit referenced.
    assign unused_addr_bits = ^{axi_awaddr_i, axi_araddr_i};

    assign axi_awready_o = aw_grant;
    assign axi_arready_o = ar_grant;
    assign axi_wready_o  = cke_i && (state_q == ST_WDATA);
    assign axi_bvalid_o  = (state_q == ST_WRESP);
    assign axi_bid_o     = id_q;
    assign axi_bresp_o   = {(state_q == ST_WRESP) && err_q, 1'b0};
    assign axi_rvalid_o  = rvalid_q;
    assign axi_rid_o     = id_q;
    assign axi_rlast_o   = rvalid_q && rlast_q;
    assign axi_rresp_o   = {rvalid_q && err_q, 1'b0};
    assign axi_rdata_o   = (rvalid_q && !err_q) ? ram_q : '0;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q   <= ST_IDLE;
            prio_q    <= 1'b0;
            id_q      <= '0;
            addr_q    <= '0;
            cnt_q     <= '0;
            fixed_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_more_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else if (cke_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (aw_grant) begin
                        state_q <= ST_WDATA;
                        prio_q  <= 1'b1;
                        id_q    <= axi_awid_i;
                        addr_q  <= axi_awaddr_i[AXI_ADDR_W-1:SIZE_LOG];
                        cnt_q   <= axi_awlen_i;
                        fixed_q <= (axi_awburst_i == 2'b00);
                        err_q   <= aw_err;
                    end else if (ar_grant) begin
                        state_q   <= ST_RDATA;
                        prio_q    <= 1'b0;
                        id_q      <= axi_arid_i;
                        addr_q    <= axi_araddr_i[AXI_ADDR_W-1:SIZE_LOG];
                        cnt_q     <= axi_arlen_i;
                        fixed_q   <= (axi_arburst_i == 2'b00);
                        err_q     <= ar_err;
                        rd_more_q <= 1'b1;
                    end
                end
                ST_WDATA: begin
                    if (w_hs) begin
                        if (!fixed_q) addr_q <= addr_q + ADDR_ONE;
                        // The beat count ends the burst; a disagreeing wlast only flags it.
                        if (axi_wlast_i != last_beat) err_q <= 1'b1;
                        if (last_beat) state_q <= ST_WRESP;
                        else           cnt_q   <= cnt_q - LEN_ONE;
                    end
                end
                ST_WRESP: begin
                    if (axi_bready_i) state_q <= ST_IDLE;
                end
                default: begin
                    if (rd_issue) begin
                        if (!fixed_q) addr_q <= addr_q + ADDR_ONE;
                        rlast_q <= last_beat;
                        if (last_beat) rd_more_q <= 1'b0;
                        else           cnt_q     <= cnt_q - LEN_ONE;
                    end
                    if (rd_issue)  rvalid_q <= 1'b1;
                    else if (r_hs) rvalid_q <= 1'b0;
                    if (r_hs && rlast_q) state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // RAM port: no reset so it can map onto block RAM; ram_q only moves on an issue.
    always_ff @(posedge clk_i) begin
        if (ram_we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (axi_wstrb_i[b]) mem[addr_q][8*b +: 8] <= axi_wdata_i[8*b +: 8];
            end
        end
        if (rd_issue) ram_q <= mem[addr_q];
    end

endmodule

// File: tb/tb_iob_axi_mem_responder.sv
// Directed bench for iob_axi_mem_responder: bursts, strobes, arbitration, errors, reset abort.
module tb_iob_axi_mem_responder;

    logic        clk = 1'b0;
    logic        arst, cke;
    logic [0:0]  awid, arid, bid, rid;
    logic [13:0] awaddr, araddr;
    logic [7:0]  awlen, arlen;
    logic [2:0]  awsize, arsize;
    logic [1:0]  awburst, arburst, bresp, rresp;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic [31:0] wdata, rdata;
    logic [3:0]  wstrb;

    logic [31:0] wd [8];
    logic [3:0]  ws [8];
    logic        wl [8];
    logic [31:0] exp_rd [8];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    iob_axi_mem_responder dut (
        .clk_i(clk), .arst_i(arst), .cke_i(cke),
        .axi_awid_i(awid), .axi_awaddr_i(awaddr), .axi_awlen_i(awlen), .axi_awsize_i(awsize),
        .axi_awburst_i(awburst), .axi_awvalid_i(awvalid), .axi_awready_o(awready),
        .axi_wdata_i(wdata), .axi_wstrb_i(wstrb), .axi_wlast_i(wlast),
        .axi_wvalid_i(wvalid), .axi_wready_o(wready),
        .axi_bid_o(bid), .axi_bresp_o(bresp), .axi_bvalid_o(bvalid), .axi_bready_i(bready),
        .axi_arid_i(arid), .axi_araddr_i(araddr), .axi_arlen_i(arlen), .axi_arsize_i(arsize),
        .axi_arburst_i(arburst), .axi_arvalid_i(arvalid), .axi_arready_o(arready),
        .axi_rid_o(rid), .axi_rdata_o(rdata), .axi_rresp_o(rresp), .axi_rlast_o(rlast),
        .axi_rvalid_o(rvalid), .axi_rready_i(rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_write(input logic [0:0] id, input logic [13:0] addr, input logic [7:0] len,
                            input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp);
        @(negedge clk);
        awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
        wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        #1;
        chk("awready", awready, 1);
        chk("aw_arready", arready, 0);
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            awvalid = 1'b0; wvalid = 1'b1; wdata = wd[i]; wstrb = ws[i]; wlast = wl[i];
            #1;
            chk("wready", wready, 1);
            chk("w_bvalid", bvalid, 0);
            chk("w_arready", arready, 0);
        end
        @(negedge clk);
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        #1;
        chk("bvalid", bvalid, 1);
        chk("bid", bid, id);
        chk("bresp", bresp, exp_resp);
    endtask

    task automatic do_read(input logic [0:0] id, input logic [13:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst, input logic [1:0] exp_resp,
                           input bit stall, input int abort_at);
        int i;
        int cyc;
        @(negedge clk);
        arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
        wvalid = 1'b0; bready = 1'b0; rready = 1'b0;
        #1;
        chk("arready", arready, 1);
        chk("ar_awready", awready, 0);
        @(negedge clk);
        arvalid = 1'b0; rready = 1'b1;
        #1;
        chk("r_gap_rvalid", rvalid, 0);
        i = 0;
        cyc = 0;
        while (i <= int'(len) && cyc < 64) begin
            @(negedge clk);
            rready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            #1;
            chk("rvalid", rvalid, 1);
            chk("rdata", rdata, exp_rd[i]);
            chk("rresp", rresp, exp_resp);
            chk("rlast", rlast, (i == int'(len)) ? 1 : 0);
            chk("rid", rid, id);
            if (rready) begin
                if (i == abort_at) return;
                i++;
            end
            cyc++;
        end
        chk("r_budget", (cyc < 64) ? 1 : 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        arst = 1'b1; cke = 1'b1;
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_wready", wready, 0);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rlast", rlast, 0);
        chk("rst_rid", rid, 0);
        chk("rst_bid", bid, 0);
        chk("rst_bresp", bresp, 0);
        @(negedge clk);
        arst = 1'b0;

        // AW and AR together from reset: write wins, then the read
        @(posedge clk);
        #1;
        arid = 1'b1; araddr = 14'h10; arlen = 8'd0; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
        wd[0] = 32'hDEADBEEF; ws[0] = 4'hF; wl[0] = 1'b1;
        do_write(1'b1, 14'h10, 8'd0, 3'd2, 2'b01, 2'b00);
        exp_rd[0] = 32'hDEADBEEF;
        do_read(1'b1, 14'h10, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0, -1);

        // INCR burst of 4 beats
        wd[0] = 32'd1; wd[1] = 32'd2; wd[2] = 32'd3; wd[3] = 32'd4;
        for (int i = 0; i < 4; i++) begin
            ws[i] = 4'hF;
            wl[i] = (i == 3);
        end
        do_write(1'b0, 14'h100, 8'd3, 3'd2, 2'b01, 2'b00);

        // After a write grant the read side wins a tie
        awid = 1'b0; awaddr = 14'h200; awlen = 8'd0; awsize = 3'd2; awburst = 2'b01; awvalid = 1'b1;
        exp_rd[0] = 32'd1; exp_rd[1] = 32'd2; exp_rd[2] = 32'd3; exp_rd[3] = 32'd4;
        do_read(1'b0, 14'h100, 8'd3, 3'd2, 2'b01, 2'b00, 1'b1, -1);

        // Partial strobes on a FIXED burst
        wd[0] = 32'hFFFFFFFF; ws[0] = 4'hF; wl[0] = 1'b1;
        do_write(1'b0, 14'h200, 8'd0, 3'd2, 2'b01, 2'b00);
        wd[0] = 32'h00000011; ws[0] = 4'h1; wl[0] = 1'b0;
        wd[1] = 32'h00000022; ws[1] = 4'h1; wl[1] = 1'b1;
        do_write(1'b1, 14'h200, 8'd1, 3'd2, 2'b00, 2'b00);
        exp_rd[0] = 32'hFFFFFF22;
        do_read(1'b1, 14'h200, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0, -1);

        // Bad awsize: SLVERR and RAM left alone
        wd[0] = 32'h12345678; ws[0] = 4'hF; wl[0] = 1'b1;
        do_write(1'b0, 14'h10, 8'd0, 3'd1, 2'b01, 2'b10);
        exp_rd[0] = 32'hDEADBEEF;
        do_read(1'b0, 14'h10, 8'd0, 3'd2, 2'b01, 2'b00, 1'b0, -1);

        // Reserved arburst: two SLVERR beats with zero data
        exp_rd[0] = 32'd0; exp_rd[1] = 32'd0;
        do_read(1'b1, 14'h100, 8'd1, 3'd2, 2'b10, 2'b10, 1'b0, -1);

        // Early wlast on beat 1 of a 4-beat burst
        wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
        wl[0] = 1'b0; wl[1] = 1'b1; wl[2] = 1'b0; wl[3] = 1'b1;
        for (int i = 0; i < 4; i++) ws[i] = 4'hF;
        do_write(1'b1, 14'h300, 8'd3, 3'd2, 2'b01, 2'b10);

        // Reset in the middle of a read burst after the first beat
        exp_rd[0] = 32'd1; exp_rd[1] = 32'd2; exp_rd[2] = 32'd3; exp_rd[3] = 32'd4;
        do_read(1'b1, 14'h100, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0, 0);
        @(negedge clk);
        rready = 1'b0;
        #2;
        arst = 1'b1;
        #1;
        chk("abort_rvalid", rvalid, 0);
        chk("abort_rdata", rdata, 0);
        chk("abort_rlast", rlast, 0);
        chk("abort_rresp", rresp, 0);
        chk("abort_rid", rid, 0);
        chk("abort_bvalid", bvalid, 0);
        @(negedge clk);
        arst = 1'b0;
        do_read(1'b0, 14'h100, 8'd3, 3'd2, 2'b01, 2'b00, 1'b0, -1);

        @(negedge clk);
        rready = 1'b0;
        #1;
        chk("end_rvalid", rvalid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
